mc_b_reader: RTL and testbench

//  Read-side controller for the MC_B byte store: drains a burst of words from a

---
 rtl/mc_b_reader.sv | 83 ++++++++
 tb/tb_mc_b_reader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_b_reader.sv
// mc_b_reader: drains a burst from a synchronous-read memory onto a valid/ready stream
module mc_b_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              StartB,
    input  logic [ADDR_W-1:0] BaseB,
    input  logic [ADDR_W:0]   LenB,
    output logic              REB,
    output logic [ADDR_W-1:0] AddrRB,
    input  logic [DATA_W-1:0] RdDataB,
    output logic [DATA_W-1:0] DataOutB,
    output logic              ValidB,
    input  logic              ReadyB,
    output logic              BusyB,
    output logic              DoneB
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_OUT, S_DONE} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [ADDR_W:0]   remaining, remaining_next;
    logic              start, accept;

    assign start  = (state == S_IDLE) && StartB;
    assign accept = (state == S_OUT) && ValidB && ReadyB;

    // state register; reset aborts any burst in flight
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // next state plus next address/count, so outputs can be registered from them
    always_comb begin
        next_state     = state;
        addr_next      = addr;
        remaining_next = remaining;
        case (state)
            S_IDLE: if (StartB) begin
                addr_next      = BaseB;
                remaining_next = LenB;
                next_state     = (LenB == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: next_state = S_WAIT;
            S_WAIT:  next_state = S_OUT;
            S_OUT: if (accept) begin
                addr_next      = addr + 1'b1;
                remaining_next = remaining - 1'b1;
                next_state     = (remaining == (ADDR_W+1)'(1)) ? S_DONE : S_FETCH;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // burst bookkeeping and registered outputs decoded from the upcoming state
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            addr      <= '0;
            remaining <= '0;
            REB       <= 1'b0;
            AddrRB    <= '0;
            DataOutB  <= '0;
            ValidB    <= 1'b0;
            BusyB     <= 1'b0;
            DoneB     <= 1'b0;
        end else begin
            if (start || accept) begin
                addr      <= addr_next;
                remaining <= remaining_next;
            end
            if (next_state == S_FETCH) AddrRB <= addr_next;
            if (state == S_WAIT) DataOutB <= RdDataB;
            REB    <= (next_state == S_FETCH);
            ValidB <= (next_state == S_OUT);
            BusyB  <= (next_state != S_IDLE);
            DoneB  <= (next_state == S_DONE);
        end
    end
endmodule

// File: tb/tb_mc_b_reader.sv
// tb_mc_b_reader: directed scenarios for the burst reader against a small memory model
module tb_mc_b_reader;
    logic       clock = 1'b0;
    logic       Reset = 1'b0;
    logic       StartB = 1'b0;
    logic [1:0] BaseB = '0;
    logic [2:0] LenB = '0;
    logic       REB;
    logic [1:0] AddrRB;
    logic [7:0] RdDataB = '0;
    logic [7:0] DataOutB;
    logic       ValidB;
    logic       ReadyB = 1'b0;
    logic       BusyB;
    logic       DoneB;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    logic [1:0] addr_log [$];
    logic [7:0] data_log [$];
    int done_cnt = 0;
    int overlap_cnt = 0;

    mc_b_reader #(.DATA_W(8), .ADDR_W(2)) dut (
        .clock(clock), .Reset(Reset), .StartB(StartB), .BaseB(BaseB), .LenB(LenB),
        .REB(REB), .AddrRB(AddrRB), .RdDataB(RdDataB), .DataOutB(DataOutB),
        .ValidB(ValidB), .ReadyB(ReadyB), .BusyB(BusyB), .DoneB(DoneB)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (REB) RdDataB <= mem[AddrRB];
        if (Reset) begin
            if (REB) addr_log.push_back(AddrRB);
            if (ValidB && ReadyB) data_log.push_back(DataOutB);
            if (DoneB) done_cnt++;
            if (REB && ValidB) overlap_cnt++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        data_log.delete();
        done_cnt = 0;
    endtask

    task automatic start_burst(input logic [1:0] base, input logic [2:0] len);
        StartB = 1'b1;
        BaseB  = base;
        LenB   = len;
        step();
        StartB = 1'b0;
        BaseB  = 2'd0;
        LenB   = 3'd0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ValidB) ok = 1'b1;
            else step();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (!BusyB) ok = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        bit ok;
        step();
        checks++;
        if ({REB, AddrRB, DataOutB, ValidB, BusyB, DoneB} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got REB=%b Addr=%0d Data=%h V=%b Busy=%b Done=%b want all 0",
                     REB, AddrRB, DataOutB, ValidB, BusyB, DoneB);
        end
        Reset = 1'b1;
        step();
        clear_logs();
        ReadyB = 1'b0;
        start_burst(2'd0, 3'd4);
        wait_valid(ok);
        checks++;
        if (!ok || DataOutB !== 8'hA0) begin
            errors++;
            $display("FAIL reset_pre_valid got ok=%b data=%h want 1/a0", ok, DataOutB);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if ({REB, AddrRB, DataOutB, ValidB, BusyB, DoneB} !== 14'd0) begin
            errors++;
            $display("FAIL reset_async got REB=%b Addr=%0d Data=%h V=%b Busy=%b Done=%b want all 0",
                     REB, AddrRB, DataOutB, ValidB, BusyB, DoneB);
        end
        step();
        Reset = 1'b1;
        step();
        step();
        checks++;
        if (BusyB !== 1'b0 || ValidB !== 1'b0 || REB !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL reset_release got Busy=%b V=%b REB=%b done=%0d want 0/0/0/0",
                     BusyB, ValidB, REB, done_cnt);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [1:0] ea [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] ed [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        clear_logs();
        ReadyB = 1'b1;
        start_burst(2'd0, 3'd4);
        checks++;
        if (REB !== 1'b1 || AddrRB !== 2'd0 || BusyB !== 1'b1) begin
            errors++;
            $display("FAIL basic_n1 got REB=%b Addr=%0d Busy=%b want 1/0/1", REB, AddrRB, BusyB);
        end
        step();
        checks++;
        if (REB !== 1'b0 || ValidB !== 1'b0) begin
            errors++;
            $display("FAIL basic_n2 got REB=%b V=%b want 0/0", REB, ValidB);
        end
        step();
        checks++;
        if (ValidB !== 1'b1 || DataOutB !== 8'hA0) begin
            errors++;
            $display("FAIL basic_n3 got V=%b data=%h want 1/a0", ValidB, DataOutB);
        end
        step();
        checks++;
        if (REB !== 1'b1 || AddrRB !== 2'd1 || ValidB !== 1'b0) begin
            errors++;
            $display("FAIL basic_n4 got REB=%b Addr=%0d V=%b want 1/1/0", REB, AddrRB, ValidB);
        end
        for (int i = 0; i < 9; i++) step();
        checks++;
        if (DoneB !== 1'b1 || BusyB !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_pulse got Done=%b Busy=%b want 1/1", DoneB, BusyB);
        end
        step();
        checks++;
        if (DoneB !== 1'b0 || BusyB !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_end got Done=%b Busy=%b want 0/0", DoneB, BusyB);
        end
        wait_idle(ok);
        checks++;
        if (!ok || addr_log.size() != 4 || data_log.size() != 4 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_counts got idle=%b addrs=%0d words=%0d done=%0d want 1/4/4/1",
                     ok, addr_log.size(), data_log.size(), done_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= addr_log.size() || i >= data_log.size() || addr_log[i] !== ea[i] || data_log[i] !== ed[i]) begin
                errors++;
                $display("FAIL basic_seq[%0d] got addr=%0d data=%h want %0d/%h", i,
                         (i < addr_log.size()) ? addr_log[i] : 2'bx, (i < data_log.size()) ? data_log[i] : 8'hxx, ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [1:0] ea [3] = '{2'd3, 2'd0, 2'd1};
        logic [7:0] ed [3] = '{8'hD3, 8'hA0, 8'hB1};
        clear_logs();
        ReadyB = 1'b1;
        start_burst(2'd3, 3'd3);
        wait_idle(ok);
        checks++;
        if (!ok || addr_log.size() != 3 || data_log.size() != 3 || done_cnt != 1) begin
            errors++;
            $display("FAIL wrap_counts got idle=%b addrs=%0d words=%0d done=%0d want 1/3/3/1",
                     ok, addr_log.size(), data_log.size(), done_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= addr_log.size() || i >= data_log.size() || addr_log[i] !== ea[i] || data_log[i] !== ed[i]) begin
                errors++;
                $display("FAIL wrap_seq[%0d] got addr=%0d data=%h want %0d/%h", i,
                         (i < addr_log.size()) ? addr_log[i] : 2'bx, (i < data_log.size()) ? data_log[i] : 8'hxx, ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_logs();
        ReadyB = 1'b0;
        start_burst(2'd0, 3'd2);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_first_valid got no ValidB want ValidB=1");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ValidB !== 1'b1 || DataOutB !== 8'hA0 || REB !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got V=%b data=%h REB=%b want 1/a0/0", i, ValidB, DataOutB, REB);
            end
            step();
        end
        ReadyB = 1'b1;
        step();
        checks++;
        if (REB !== 1'b1 || AddrRB !== 2'd1 || ValidB !== 1'b0) begin
            errors++;
            $display("FAIL bp_resume got REB=%b Addr=%0d V=%b want 1/1/0", REB, AddrRB, ValidB);
        end
        step();
        step();
        checks++;
        if (ValidB !== 1'b1 || DataOutB !== 8'hB1) begin
            errors++;
            $display("FAIL bp_second got V=%b data=%h want 1/b1", ValidB, DataOutB);
        end
        wait_idle(ok);
        checks++;
        if (!ok || data_log.size() != 2 || done_cnt != 1 || addr_log.size() != 2) begin
            errors++;
            $display("FAIL bp_counts got idle=%b words=%0d addrs=%0d done=%0d want 1/2/2/1",
                     ok, data_log.size(), addr_log.size(), done_cnt);
        end
    endtask

    task automatic test_empty_ignored();
        bit ok;
        logic [7:0] ed [3] = '{8'hA0, 8'hB1, 8'hC2};
        clear_logs();
        ReadyB = 1'b1;
        start_burst(2'd2, 3'd0);
        checks++;
        if (DoneB !== 1'b1 || REB !== 1'b0 || BusyB !== 1'b1) begin
            errors++;
            $display("FAIL empty_done got Done=%b REB=%b Busy=%b want 1/0/1", DoneB, REB, BusyB);
        end
        step();
        checks++;
        if (DoneB !== 1'b0 || BusyB !== 1'b0 || addr_log.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL empty_end got Done=%b Busy=%b reads=%0d done=%0d want 0/0/0/1",
                     DoneB, BusyB, addr_log.size(), done_cnt);
        end
        clear_logs();
        start_burst(2'd0, 3'd3);
        step();
        StartB = 1'b1;
        BaseB  = 2'd2;
        LenB   = 3'd1;
        step();
        step();
        StartB = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || data_log.size() != 3 || done_cnt != 1 || addr_log.size() != 3) begin
            errors++;
            $display("FAIL ignored_counts got idle=%b words=%0d addrs=%0d done=%0d want 1/3/3/1",
                     ok, data_log.size(), addr_log.size(), done_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= data_log.size() || data_log[i] !== ed[i]) begin
                errors++;
                $display("FAIL ignored_seq[%0d] got data=%h want %h", i,
                         (i < data_log.size()) ? data_log[i] : 8'hxx, ed[i]);
            end
        end
    endtask

    task automatic test_long();
        bit ok;
        logic [1:0] ea [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        logic [7:0] ed [6] = '{8'hB1, 8'hC2, 8'hD3, 8'hA0, 8'hB1, 8'hC2};
        clear_logs();
        ReadyB = 1'b1;
        start_burst(2'd1, 3'd6);
        wait_idle(ok);
        checks++;
        if (!ok || addr_log.size() != 6 || data_log.size() != 6 || done_cnt != 1) begin
            errors++;
            $display("FAIL long_counts got idle=%b addrs=%0d words=%0d done=%0d want 1/6/6/1",
                     ok, addr_log.size(), data_log.size(), done_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= addr_log.size() || i >= data_log.size() || addr_log[i] !== ea[i] || data_log[i] !== ed[i]) begin
                errors++;
                $display("FAIL long_seq[%0d] got addr=%0d data=%h want %0d/%h", i,
                         (i < addr_log.size()) ? addr_log[i] : 2'bx, (i < data_log.size()) ? data_log[i] : 8'hxx, ea[i], ed[i]);
            end
        end
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL reb_valid_overlap got %0d cycles want 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_empty_ignored();
        test_long();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
